// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the
// load/store unit. One transaction is outstanding at a time. LSU has fixed
// priority, except that fetch wins once it has waited through STARVE_MAX
// consecutive LSU grants. LSU accesses are encoded into word address, byte
// enables and lane-replicated store data; load data is aligned and extended
// on return. Misaligned or illegal LSU accesses are answered locally with an
// error response and never reach memory.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_sign_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  typedef enum logic {StIdle, StWaitRsp} state_e;
  typedef enum logic {OwnIf, OwnLs} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic            we_q, we_d;
  logic [CntW-1:0] starve_q, starve_d;

  logic            if_rvalid_q, if_rvalid_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic            ls_rvalid_q, ls_rvalid_d;
  logic [31:0]     ls_rdata_q, ls_rdata_d;
  logic            ls_err_q, ls_err_d;

  logic            if_gnt, ls_gnt, mem_req, mem_we;
  logic [31:0]     mem_addr, mem_wdata;
  logic [3:0]      mem_be;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_shifted, ld_ext;

  // Fetch addresses are word aligned by contract; low bits are dropped.
  logic unused_if_addr;
  assign unused_if_addr = ^if_addr_i[1:0];

  // Arbitration: LSU first unless fetch has hit the starvation limit.
  logic starve_hit, sel_ls, sel_if, ls_misal, ls_illegal, ls_bad;
  assign starve_hit = if_req_i && (starve_q == CntW'(STARVE_MAX));
  assign sel_ls     = ls_req_i && !starve_hit;
  assign sel_if     = if_req_i && !sel_ls;
  assign ls_misal   = (ls_size_i == 2'b01 && ls_addr_i[0]) ||
                      (ls_size_i == 2'b10 && ls_addr_i[1:0] != 2'b00);
  assign ls_illegal = (ls_size_i == 2'b11) ||
                      (ls_size_i == 2'b10 && !ls_we_i && ls_sign_i);
  assign ls_bad     = ls_misal || ls_illegal;

  // Store byte enables and lane-replicated write data.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ls_wdata_i;
    case (ls_size_i)
      2'b00: begin
        st_be    = 4'b0001 << ls_addr_i[1:0];
        st_wdata = {4{ls_wdata_i[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {ls_addr_i[1], 1'b0};
        st_wdata = {2{ls_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment and extension; sign_q = 0 means signed.
  always_comb begin
    ld_shifted = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_ext = {{24{~sign_q & ld_shifted[7]}}, ld_shifted[7:0]};
      2'b01:   ld_ext = {{16{~sign_q & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_ext = ld_shifted;
    endcase
  end

  // Next-state, port drive, response capture and starvation counting.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    off_d       = off_q;
    size_d      = size_q;
    sign_d      = sign_q;
    we_d        = we_q;
    starve_d    = starve_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = '0;
    mem_wdata   = '0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = '0;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = '0;
    ls_err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel_ls && ls_bad) begin
          // Answered locally: grant now, error response next cycle.
          ls_gnt      = 1'b1;
          ls_rvalid_d = 1'b1;
          ls_err_d    = 1'b1;
        end else if (sel_ls) begin
          mem_req   = 1'b1;
          mem_we    = ls_we_i;
          mem_addr  = {ls_addr_i[31:2], 2'b00};
          mem_be    = ls_we_i ? st_be : 4'b1111;
          mem_wdata = ls_we_i ? st_wdata : '0;
          if (mem_gnt_i) begin
            ls_gnt  = 1'b1;
            state_d = StWaitRsp;
            owner_d = OwnLs;
            off_d   = ls_addr_i[1:0];
            size_d  = ls_size_i;
            sign_d  = ls_sign_i;
            we_d    = ls_we_i;
          end
        end else if (sel_if) begin
          mem_req  = 1'b1;
          mem_addr = {if_addr_i[31:2], 2'b00};
          mem_be   = 4'b1111;
          if (mem_gnt_i) begin
            if_gnt  = 1'b1;
            state_d = StWaitRsp;
            owner_d = OwnIf;
            off_d   = 2'b00;
            size_d  = 2'b10;
            sign_d  = 1'b0;
            we_d    = 1'b0;
          end
        end
      end
      StWaitRsp: begin
        if (mem_rvalid_i) begin
          state_d = StIdle;
          if (owner_q == OwnIf) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = we_q ? '0 : ld_ext;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!if_req_i || if_gnt) begin
      starve_d = '0;
    end else if (ls_gnt && starve_q != CntW'(STARVE_MAX)) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  // State and registered responses, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      off_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      we_q        <= we_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
    end
  end

  // Every output is forced low while reset is held.
  assign if_gnt_o    = if_gnt & ~rst;
  assign ls_gnt_o    = ls_gnt & ~rst;
  assign mem_req_o   = mem_req & ~rst;
  assign mem_we_o    = mem_we & ~rst;
  assign mem_addr_o  = rst ? '0 : mem_addr;
  assign mem_be_o    = rst ? '0 : mem_be;
  assign mem_wdata_o = rst ? '0 : mem_wdata;
  assign if_rvalid_o = if_rvalid_q & ~rst;
  assign if_rdata_o  = rst ? '0 : if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q & ~rst;
  assign ls_rdata_o  = rst ? '0 : ls_rdata_q;
  assign ls_err_o    = ls_err_q & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus randomized traffic against a
// transaction-level reference model. Expected responses are queued by the
// driver and consumed by an independent monitor when the DUT responds.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ls_req_i, ls_we_i, ls_sign_i, ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_size_i(ls_size_i),
    .ls_sign_i(ls_sign_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  logic any_out;
  assign any_out = |{if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
                     ls_err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t ls_q[$];

  // Reference model state: one outstanding transaction, starvation count.
  bit          m_busy;
  int          m_owner;  // 1 = fetch, 2 = LSU
  logic        m_we, m_sign;
  logic [1:0]  m_size, m_off;
  int unsigned m_starve;
  bit          last_if_gnt, last_ls_gnt;
  bit          rec_order;
  string       order;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit ls_bad(logic we, logic [1:0] size, logic sign, logic [31:0] addr);
    int nb;
    if (size == 2'b11) return 1'b1;
    if (size == 2'b10 && !we && sign) return 1'b1;
    nb = 1 << size;
    return (addr % nb) != 0;
  endfunction

  function automatic logic [3:0] st_be(logic [1:0] size, logic [1:0] off);
    int b;
    b = ((1 << (1 << size)) - 1) << off;
    return b[3:0];
  endfunction

  function automatic logic [31:0] st_data(logic [1:0] size, logic [31:0] wd);
    logic [31:0] w;
    int nb;
    nb = 1 << size;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] load_val(logic [1:0] size, logic sign, logic [1:0] off,
                                           logic [31:0] rd);
    int nbits;
    logic [63:0] mask, v;
    nbits = 8 << size;
    mask  = (64'd1 << nbits) - 64'd1;
    v     = ({32'd0, rd} >> (8 * off)) & mask;
    if (!sign && v[nbits-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Evaluate one cycle of the reference model against the current inputs.
  task automatic model_eval();
    bit   e_if, e_ls, e_req;
    int   win;
    rsp_t r;
    e_if = 0; e_ls = 0; e_req = 0; win = 0;
    if (!m_busy) begin
      if (ls_req_i && !(if_req_i && m_starve == STARVE_MAX)) win = 2;
      else if (if_req_i) win = 1;
      if (win == 2 && ls_bad(ls_we_i, ls_size_i, ls_sign_i, ls_addr_i)) begin
        e_ls = 1;
        r.data = 32'd0; r.err = 1'b1;
        ls_q.push_back(r);
      end else if (win == 2) begin
        e_req = 1;
        chk("ls_mem_addr", mem_addr_o, ls_addr_i & ~32'd3);
        chk("ls_mem_we", 32'(mem_we_o), 32'(ls_we_i));
        chk("ls_mem_be", 32'(mem_be_o),
            ls_we_i ? 32'(st_be(ls_size_i, ls_addr_i[1:0])) : 32'hF);
        if (ls_we_i) chk("ls_mem_wdata", mem_wdata_o, st_data(ls_size_i, ls_wdata_i));
        if (mem_gnt_i) begin
          e_ls = 1; m_busy = 1; m_owner = 2;
          m_we = ls_we_i; m_size = ls_size_i; m_sign = ls_sign_i; m_off = ls_addr_i[1:0];
        end
      end else if (win == 1) begin
        e_req = 1;
        chk("if_mem_addr", mem_addr_o, if_addr_i & ~32'd3);
        chk("if_mem_be_we", 32'({mem_be_o, mem_we_o}), 32'h1E);
        if (mem_gnt_i) begin
          e_if = 1; m_busy = 1; m_owner = 1;
        end
      end
    end else if (mem_rvalid_i) begin
      m_busy = 0;
      r.err = 1'b0;
      if (m_owner == 1) begin
        r.data = mem_rdata_i;
        if_q.push_back(r);
      end else begin
        r.data = m_we ? 32'd0 : load_val(m_size, m_sign, m_off, mem_rdata_i);
        ls_q.push_back(r);
      end
    end
    chk("gnt_req", 32'({if_gnt_o, ls_gnt_o, mem_req_o}), 32'({e_if, e_ls, e_req}));
    if (!if_req_i || e_if) m_starve = 0;
    else if (e_ls && m_starve < STARVE_MAX) m_starve++;
    if (rec_order && e_ls) order = {order, "L"};
    if (rec_order && e_if) order = {order, "I"};
    last_if_gnt = e_if;
    last_ls_gnt = e_ls;
  endtask

  task automatic model_reset();
    m_busy = 0; m_starve = 0; last_if_gnt = 0; last_ls_gnt = 0;
    if_q.delete(); ls_q.delete();
  endtask

  task automatic step();
    @(negedge clk);
    if (rst) model_reset();
    else model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; ls_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  // Hold reset with every input active; all outputs must stay low.
  task automatic do_reset(int n);
    rst = 1; if_req_i = 1; ls_req_i = 1; ls_we_i = 1; ls_size_i = 2'b00;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = $urandom;
    repeat (n) begin
      @(negedge clk);
      chk("reset_outputs_zero", 32'(any_out), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic rand_cycle(int p_if, int p_ls, int p_gnt, int p_rv, int p_spur, bit legal);
    if (last_if_gnt) if_req_i = 0;
    if (last_ls_gnt) ls_req_i = 0;
    if (!if_req_i && $urandom_range(99) < p_if) begin
      if_req_i = 1; if_addr_i = $urandom;
    end
    if (!ls_req_i && $urandom_range(99) < p_ls) begin
      ls_req_i   = 1;
      ls_we_i    = 1'($urandom_range(1));
      ls_size_i  = 2'($urandom_range(3));
      ls_sign_i  = 1'($urandom_range(1));
      ls_addr_i  = $urandom;
      ls_wdata_i = $urandom;
      if (legal || $urandom_range(1) == 0) begin
        ls_size_i = 2'($urandom_range(2));
        ls_addr_i = ls_addr_i & ~((32'd1 << ls_size_i) - 32'd1);
        if (ls_size_i == 2'b10 && !ls_we_i) ls_sign_i = 1'b0;
      end
    end
    mem_gnt_i    = $urandom_range(99) < p_gnt;
    mem_rvalid_i = m_busy ? ($urandom_range(99) < p_rv) : ($urandom_range(99) < p_spur);
    mem_rdata_i  = $urandom;
    step();
  endtask

  task automatic dir_if(logic [31:0] addr, logic [31:0] rdata);
    idle_inputs(); if_req_i = 1; if_addr_i = addr; mem_gnt_i = 1;
    @(negedge clk);
    chk("if_dir_gnt", 32'({mem_req_o, if_gnt_o, mem_be_o}), 32'h3F);
    model_eval();
    @(posedge clk); #1;
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = rdata;
    @(negedge clk);
    chk("if_dir_early_rvalid", 32'(if_rvalid_o), 32'd0);
    model_eval();
    @(posedge clk); #1;
    mem_rvalid_i = 0;
    @(negedge clk);
    chk("if_dir_rsp", 32'(if_rvalid_o), 32'd1);
    chk("if_dir_rdata", if_rdata_o, rdata);
    model_eval();
    @(posedge clk); #1;
    @(negedge clk);
    chk("if_dir_rvalid_one_cycle", 32'(if_rvalid_o), 32'd0);
    model_eval();
    @(posedge clk); #1;
  endtask

  task automatic dir_ls(string name, logic we, logic [1:0] size, logic sign, logic [31:0] addr,
                        logic [31:0] wdata, logic [31:0] rdata, logic [31:0] exp_data,
                        logic exp_err, logic [31:0] exp_addr, logic [3:0] exp_be,
                        logic [31:0] exp_wdata);
    idle_inputs();
    ls_req_i = 1; ls_we_i = we; ls_size_i = size; ls_sign_i = sign;
    ls_addr_i = addr; ls_wdata_i = wdata; mem_gnt_i = 1;
    @(negedge clk);
    if (exp_err) begin
      chk({name, "_err_gnt"}, 32'({mem_req_o, ls_gnt_o}), 32'h1);
    end else begin
      chk({name, "_gnt"}, 32'({mem_req_o, ls_gnt_o, mem_we_o}), 32'({2'b11, we}));
      chk({name, "_addr"}, mem_addr_o, exp_addr);
      chk({name, "_be"}, 32'(mem_be_o), 32'(exp_be));
      if (we) chk({name, "_wdata"}, mem_wdata_o, exp_wdata);
    end
    model_eval();
    @(posedge clk); #1;
    ls_req_i = 0; mem_gnt_i = 0;
    if (!exp_err) begin
      mem_rvalid_i = 1; mem_rdata_i = rdata;
      step();
      mem_rvalid_i = 0;
    end
    @(negedge clk);
    chk({name, "_rvalid_err"}, 32'({ls_rvalid_o, ls_err_o}), 32'({1'b1, exp_err}));
    chk({name, "_rdata"}, ls_rdata_o, exp_data);
    model_eval();
    @(posedge clk); #1;
  endtask

  // Monitor: consumes queued expectations whenever the DUT responds.
  always @(negedge clk) begin
    rsp_t r;
    if (!rst) begin
      if (if_rvalid_o) begin
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_unexpected_rvalid: got rvalid=1 rdata=0x%08h expected no response",
                   if_rdata_o);
        end else begin
          r = if_q.pop_front();
          chk("mon_if_rdata", if_rdata_o, r.data);
        end
      end
      if (ls_rvalid_o) begin
        if (ls_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ls_unexpected_rvalid: got rvalid=1 rdata=0x%08h expected no response",
                   ls_rdata_o);
        end else begin
          r = ls_q.pop_front();
          chk("mon_ls_rdata", ls_rdata_o, r.data);
          chk("mon_ls_err", 32'(ls_err_o), 32'(r.err));
        end
      end
    end
  end

  initial begin
    rst = 1; if_addr_i = 0; ls_we_i = 0; ls_addr_i = 0; ls_size_i = 0; ls_sign_i = 0;
    ls_wdata_i = 0; mem_rdata_i = 0; rec_order = 0; order = "";
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    do_reset(3);

    dir_if(32'h100, 32'h0000_0013);

    dir_ls("lb",  0, 2'b00, 0, 32'h203, 0, 32'h80FF_FF01, 32'hFFFF_FF80, 0, 32'h200, 4'hF, 0);
    dir_ls("lbu", 0, 2'b00, 1, 32'h203, 0, 32'h80FF_FF01, 32'h0000_0080, 0, 32'h200, 4'hF, 0);
    dir_ls("lhu", 0, 2'b01, 1, 32'h202, 0, 32'h80FF_FF01, 32'h0000_80FF, 0, 32'h200, 4'hF, 0);
    dir_ls("lh",  0, 2'b01, 0, 32'h202, 0, 32'h80FF_FF01, 32'hFFFF_80FF, 0, 32'h200, 4'hF, 0);
    dir_ls("lw",  0, 2'b10, 0, 32'h104, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 32'h104, 4'hF, 0);
    dir_ls("sh",  1, 2'b01, 0, 32'h206, 32'h1234_ABCD, 32'h5555_5555, 32'h0, 0,
           32'h204, 4'hC, 32'hABCD_ABCD);
    dir_ls("sb",  1, 2'b00, 1, 32'h301, 32'h0000_005A, 32'h0, 32'h0, 0,
           32'h300, 4'h2, 32'h5A5A_5A5A);
    dir_ls("lw_mis",  0, 2'b10, 0, 32'h102, 0, 0, 32'h0, 1, 0, 0, 0);
    dir_ls("size11",  0, 2'b11, 0, 32'h100, 0, 0, 32'h0, 1, 0, 0, 0);
    dir_ls("lwu_ill", 0, 2'b10, 1, 32'h100, 0, 0, 32'h0, 1, 0, 0, 0);
    dir_ls("sh_mis",  1, 2'b01, 0, 32'h201, 0, 0, 32'h0, 1, 0, 0, 0);

    // Back-to-back error grants: second grant coincides with first response.
    idle_inputs();
    ls_req_i = 1; ls_we_i = 0; ls_size_i = 2'b11; ls_addr_i = 32'h0;
    step();
    ls_size_i = 2'b10; ls_addr_i = 32'h102;
    @(negedge clk);
    chk("err_back_to_back", 32'({ls_gnt_o, ls_rvalid_o, ls_err_o}), 32'h7);
    model_eval();
    @(posedge clk); #1;
    ls_req_i = 0;
    step();
    step();

    // Reset while a fetch is outstanding; the late response must be dropped.
    idle_inputs(); if_req_i = 1; if_addr_i = 32'h40; mem_gnt_i = 1;
    step();
    do_reset(1);
    mem_rvalid_i = 1; mem_rdata_i = 32'h0BAD_0BAD;
    step();
    mem_rvalid_i = 0;
    @(negedge clk);
    chk("reset_drops_rsp", 32'({if_rvalid_o, ls_rvalid_o}), 32'd0);
    model_eval();
    @(posedge clk); #1;
    dir_if(32'h100, 32'h0000_0013);

    // Both requesters saturated, single-cycle memory.
    do_reset(2);
    order = ""; rec_order = 1;
    repeat (30) rand_cycle(100, 100, 100, 100, 0, 1);
    rec_order = 0;
    checks++;
    if (order.len() < 10 || order.substr(0, 9) != "LLLLILLLLI") begin
      errors++;
      $display("FAIL starve_order: got %s expected LLLLILLLLI...", order);
    end
    repeat (20) rand_cycle(0, 0, 100, 100, 0, 1);

    // Randomized traffic, then drain.
    do_reset(2);
    repeat (4000) rand_cycle(60, 60, 70, 50, 10, 0);
    repeat (30) rand_cycle(0, 0, 100, 100, 0, 1);
    chk("drain_if_q_empty", 32'(if_q.size()), 32'd0);
    chk("drain_ls_q_empty", 32'(ls_q.size()), 32'd0);
    chk("drain_model_idle", 32'(m_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between instruction fetch (IF) and the load/store unit (LSU), one transaction outstanding at a time. It sits between the fetch stage / LSU and the memory.
- For LSU accesses it derives word address, byte enables and lane-replicated store data from the `size_t`/`sign_t` encodings in the `riscv` package (funct3 = {sign, size}).
- It aligns and sign/zero-extends load data on return and flags misaligned or illegal accesses.
- Fixed LSU priority with a starvation guard for fetch.

## Interface
Parameters:
- STARVE_MAX, 4, consecutive LSU grants with IF pending after which IF gets priority (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held stable with if_addr_i until if_gnt_o
- if_addr_i  in  32  fetch address; word aligned, bits [1:0] ignored
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  32  fetched instruction
- ls_req_i  in  1  LSU request; held stable with all ls_* inputs until ls_gnt_o
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  32  byte address
- ls_size_i  in  2  BYTE=00, HWORD=01, WORD=10; 11 illegal
- ls_sign_i  in  1  SIGNED=0, UNSIGNED=1; ignored for stores
- ls_wdata_i  in  32  store data, right-justified
- ls_gnt_o  out  1  LSU request accepted this cycle
- ls_rvalid_o  out  1  LSU response valid (loads and stores)
- ls_rdata_o  out  32  extended load data; 0 for stores and errors
- ls_err_o  out  1  qualifies ls_rvalid_o: misaligned or illegal access
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  32  word address, bits [1:0] = 0
- mem_be_o  out  4  byte enables; 4'b1111 for IF and loads
- mem_wdata_o  out  32  lane-replicated store data
- mem_gnt_i  in  1  memory accepts the request this cycle
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data

## Operation
FSM with states IDLE and WAIT_RSP.

IDLE:
- Select LSU if ls_req_i, else IF.
- IF wins instead when if_req_i and starve_cnt == STARVE_MAX.
- Selected request drives mem_* combinationally; mem_req_o = 1.
- mem_req_o && mem_gnt_i: assert the selected gnt_o the same cycle, latch owner, addr[1:0], size, sign, we; go to WAIT_RSP.
- Selected LSU request misaligned or illegal: no mem_req_o. ls_gnt_o = 1 this cycle, ls_rvalid_o = ls_err_o = 1 next cycle, ls_rdata_o = 0. Stay in IDLE.
  - Misaligned: HWORD with addr[0] = 1, or WORD with addr[1:0] ≠ 0.
  - Illegal: size 11, or UNSIGNED WORD load.

WAIT_RSP:
- mem_req_o = 0; no grants.
- On mem_rvalid_i, register the response to the owner's rvalid/rdata and return to IDLE.

Store encoding:
- mem_be_o: BYTE = 0001 << addr[1:0]; HWORD = 0011 << {addr[1],0}; WORD = 1111.
- mem_wdata_o: BYTE = {4{wdata[7:0]}}; HWORD = {2{wdata[15:0]}}; WORD = wdata.

Load return:
- Shift mem_rdata_i right by 8·addr[1:0].
- Take 8/16/32 bits; sign-extend if SIGNED, zero-extend if UNSIGNED.

Starvation counter (starve_cnt, width clog2(STARVE_MAX+1)):
- +1 on each LSU grant (error grants included) while if_req_i = 1, saturating at STARVE_MAX.
- Cleared on an IF grant or when if_req_i = 0.

Boundary cases:
- mem_rvalid_i in IDLE is ignored.
- New requests during WAIT_RSP are held off; requesters keep waiting.
- Reset mid-transaction: FSM to IDLE, outstanding response dropped; a later mem_rvalid_i is ignored.

## Timing
- Reset: while rst = 1, all outputs are 0 (mem_req_o gated by rst), FSM is IDLE, starve_cnt = 0.
- Grants are combinational from mem_gnt_i; at most one grant per cycle.
- Grant at cycle T, mem_rvalid_i earliest at T+1, rvalid_o at T+2.
- rvalid_o and rdata_o are registered and high for exactly one cycle.
- FSM is back in IDLE in the rvalid_o cycle, so back-to-back throughput is one transaction per 2 cycles with single-cycle memory.
- Error response: gnt at T, ls_rvalid_o/ls_err_o at T+1; the next grant can occur at T+1.

## Test plan
- IF only, addr 0x100, mem_gnt_i at T, mem_rvalid_i = 0x00000013 at T+1 → if_gnt_o at T, if_rvalid_o at T+2 with if_rdata_o = 0x00000013, mem_be_o = 1111.
- LSU lb at 0x203, mem_rdata_i = 0x80FF_FF01 → ls_rdata_o = 0xFFFFFF80. Same with lbu → 0x00000080. lhu at 0x202 → 0x000080FF.
- LSU sh at 0x206 with wdata 0x1234ABCD → mem_addr_o = 0x204, mem_be_o = 1100, mem_wdata_o = 0xABCDABCD, mem_we_o = 1; ls_rvalid_o with rdata 0, err 0.
- LSU lw at 0x102, and size 11 → no mem_req_o; ls_gnt_o at T, ls_rvalid_o = ls_err_o = 1 at T+1.
- IF and LSU both requesting continuously, STARVE_MAX = 4 → grant order L,L,L,L,I,L,L,L,L,I,…
- rst asserted in WAIT_RSP, mem_rvalid_i on the next cycle → no rvalid_o; all outputs 0 during reset; normal fetch succeeds afterwards.
